fetch_sequencer: RTL and testbench

Instruction-fetch controller for the 8-bit core. It owns the 6-bit program counter and sequences reads from the 64 x 16-bit instruction memory. It presents each fetched word to decode through a valid/ready handshake and handles branch redirects plus a HALT/resume stop. It sits between the instruction memory (registered read, one-cycle latency) and the decode/control stage.

---
 rtl/fetch_sequencer.sv | 98 +++++++++
 tb/tb_fetch_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one registered-read memory
// request per instruction, presents the word to decode and handles redirect/HALT.
module fetch_sequencer #(
    parameter int                ADDR_W   = 6,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              resume,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        RESP  = 3'd2,
        VALID = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   pc_reg, pc_next;
    logic [DATA_W-1:0]   ir_reg, ir_next;
    logic [ADDR_W-1:0]   ir_pc_reg, ir_pc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            ir_reg    <= '0;
            ir_pc_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            ir_pc_reg <= ir_pc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        ir_pc_next = ir_pc_reg;

        case (state_reg)
            IDLE:  state_next = REQ;
            REQ:   state_next = RESP;
            RESP: begin
                ir_next    = mem_rdata;
                ir_pc_next = pc_reg;
                pc_next    = pc_reg + ADDR_W'(1);
                state_next = VALID;
            end
            VALID: begin
                if (ir_ready)
                    state_next = (ir_reg[DATA_W-1 -: 4] == HALT_OP) ? HALT : REQ;
            end
            HALT: begin
                if (resume)
                    state_next = REQ;
            end
            default: state_next = IDLE;
        endcase

        // Redirect overrides everything; outside HALT it also drops any
        // in-flight read so the stale word never reaches ir.
        if (redirect) begin
            pc_next = redirect_pc;
            if (state_reg != HALT) begin
                state_next = REQ;
                ir_next    = ir_reg;
                ir_pc_next = ir_pc_reg;
            end
        end
    end

    assign mem_en   = (state_reg == REQ);
    assign mem_addr = pc_reg;
    assign ir       = ir_reg;
    assign ir_pc    = ir_pc_reg;
    assign ir_valid = (state_reg == VALID);
    assign halted   = (state_reg == HALT);
    assign pc       = pc_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural fetch model checked every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_en;
    logic [5:0]  mem_addr;
    logic [15:0] mem_rdata = '0;
    logic [15:0] ir;
    logic [5:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [5:0]  redirect_pc = '0;
    logic        resume = 1'b0;
    logic        halted;
    logic [5:0]  pc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] mem [64];

    fetch_sequencer dut (
        .clk(clk), .reset(reset),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .resume(resume),
        .halted(halted), .pc(pc)
    );

    always #5 clk = ~clk;

    // Registered-read memory; junk data when not strobed exposes mistimed loads.
    always @(posedge clk) begin
        mem_rdata <= mem_en ? mem[mem_addr] : 16'($urandom);
        cyc       <= cyc + 1;
    end

    // Behavioural model: what is outstanding, what is held for decode, stopped or not.
    logic       m_boot, m_issue, m_flight, m_have, m_stopped;
    logic [5:0] m_pc, m_ir_pc;
    logic [15:0] m_ir;
    logic [15:0] d_ir[$];
    logic [5:0]  d_pc[$];
    int          d_cyc[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_boot <= 1'b1; m_issue <= 1'b0; m_flight <= 1'b0;
            m_have <= 1'b0; m_stopped <= 1'b0;
            m_pc <= 6'd0; m_ir <= 16'd0; m_ir_pc <= 6'd0;
        end else if (m_stopped) begin
            if (redirect) m_pc <= redirect_pc;
            if (resume) begin
                m_stopped <= 1'b0;
                m_issue   <= 1'b1;
            end
        end else if (redirect) begin
            if (m_have && ir_ready) begin
                d_ir.push_back(m_ir); d_pc.push_back(m_ir_pc); d_cyc.push_back(cyc);
            end
            m_pc <= redirect_pc;
            m_boot <= 1'b0; m_issue <= 1'b1; m_flight <= 1'b0; m_have <= 1'b0;
        end else if (m_boot) begin
            m_boot  <= 1'b0;
            m_issue <= 1'b1;
        end else if (m_issue) begin
            m_issue  <= 1'b0;
            m_flight <= 1'b1;
        end else if (m_flight) begin
            m_flight <= 1'b0;
            m_have   <= 1'b1;
            m_ir     <= mem[m_pc];
            m_ir_pc  <= m_pc;
            m_pc     <= m_pc + 6'd1;
        end else if (m_have && ir_ready) begin
            d_ir.push_back(m_ir); d_pc.push_back(m_ir_pc); d_cyc.push_back(cyc);
            m_have <= 1'b0;
            if (m_ir[15:12] == 4'hF) m_stopped <= 1'b1;
            else                     m_issue   <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_mem_en",   32'(mem_en),   32'(m_issue));
        chk("model_mem_addr", 32'(mem_addr), 32'(m_pc));
        chk("model_pc",       32'(pc),       32'(m_pc));
        chk("model_ir_valid", 32'(ir_valid), 32'(m_have));
        chk("model_halted",   32'(halted),   32'(m_stopped));
        chk("model_ir",       32'(ir),       32'(m_ir));
        chk("model_ir_pc",    32'(ir_pc),    32'(m_ir_pc));
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!ir_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid_timeout", 32'(ir_valid), 32'd1);
    endtask

    logic [15:0] hold_ir;
    logic [5:0]  hold_pc;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0100 + 16'(i);
        mem[3]  = 16'hF000;
        mem[63] = 16'h1234;

        #1 reset = 1'b1;
        step(); step();
        chk("reset_ir_valid", 32'(ir_valid), 32'd0);
        chk("reset_pc",       32'(pc),       32'd0);
        chk("reset_mem_en",   32'(mem_en),   32'd0);
        chk("reset_halted",   32'(halted),   32'd0);
        chk("reset_ir",       32'(ir),       32'd0);

        // Sequential fetch through the HALT word at address 3.
        ir_ready = 1'b1;
        reset = 1'b0;
        step();
        chk("seq_first_mem_en", 32'(mem_en), 32'd1);
        chk("seq_first_addr",   32'(mem_addr), 32'd0);
        step(); step();
        chk("seq_first_valid", 32'(ir_valid), 32'd1);
        chk("seq_first_ir",    32'(ir),       32'h0100);
        chk("seq_first_ir_pc", 32'(ir_pc),    32'd0);
        begin
            int n = 0;
            while (!halted && n < 40) begin step(); n++; end
        end
        chk("seq_halted", 32'(halted), 32'd1);
        chk("seq_count", 32'(d_ir.size()), 32'd4);
        if (d_ir.size() == 4) begin
            chk("seq_ir0", 32'(d_ir[0]), 32'h0100);
            chk("seq_ir1", 32'(d_ir[1]), 32'h0101);
            chk("seq_ir2", 32'(d_ir[2]), 32'h0102);
            chk("seq_ir3", 32'(d_ir[3]), 32'hF000);
            chk("seq_pc2", 32'(d_pc[2]), 32'd2);
            chk("seq_spacing", 32'(d_cyc[1] - d_cyc[0]), 32'd3);
        end

        // HALT holds for 10 cycles, then resume restarts at address 4.
        for (int i = 0; i < 10; i++) begin
            chk("halt_stays", 32'(halted), 32'd1);
            chk("halt_no_mem_en", 32'(mem_en), 32'd0);
            step();
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("resume_mem_en", 32'(mem_en), 32'd1);
        chk("resume_addr",   32'(mem_addr), 32'd4);
        chk("resume_halted", 32'(halted), 32'd0);

        // Backpressure on the address-4 word.
        ir_ready = 1'b0;
        wait_valid(10);
        hold_ir = ir;
        hold_pc = ir_pc;
        chk("bp_ir_lit", 32'(hold_ir), 32'h0104);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ir_hold",  32'(ir),       32'(hold_ir));
            chk("bp_pc_hold",  32'(ir_pc),    32'(hold_pc));
            chk("bp_valid",    32'(ir_valid), 32'd1);
            chk("bp_no_mem",   32'(mem_en),   32'd0);
            chk("bp_pc_const", 32'(pc),       32'd5);
        end
        ir_ready = 1'b1;
        step();

        // Wrap: redirect to 63, next fetch after it is address 0.
        redirect = 1'b1; redirect_pc = 6'd63;
        step();
        redirect = 1'b0;
        chk("wrap_req_addr", 32'(mem_addr), 32'd63);
        wait_valid(10);
        chk("wrap_ir",    32'(ir),    32'h1234);
        chk("wrap_ir_pc", 32'(ir_pc), 32'd63);
        step();
        chk("wrap_next_mem_en", 32'(mem_en), 32'd1);
        chk("wrap_next_addr",   32'(mem_addr), 32'd0);

        // Redirect during RESP of address 5 discards that word.
        redirect = 1'b1; redirect_pc = 6'd5;
        step();
        redirect = 1'b0;
        chk("rdr_req5", 32'(mem_addr), 32'd5);
        step();
        d_ir.delete(); d_pc.delete(); d_cyc.delete();
        redirect = 1'b1; redirect_pc = 6'd20;
        step();
        redirect = 1'b0;
        chk("rdr_mem_en",   32'(mem_en),   32'd1);
        chk("rdr_addr",     32'(mem_addr), 32'd20);
        chk("rdr_no_valid", 32'(ir_valid), 32'd0);
        wait_valid(10);
        chk("rdr_ir_pc", 32'(ir_pc), 32'd20);
        chk("rdr_ir",    32'(ir),    32'h0114);
        step();
        chk("rdr_deliveries", 32'(d_pc.size()), 32'd1);
        if (d_pc.size() == 1) chk("rdr_delivered_pc", 32'(d_pc[0]), 32'd20);

        // Randomized phase on randomized memory.
        reset = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 500; i++) begin
            ir_ready    = ($urandom % 4) != 0;
            redirect    = ($urandom % 16) == 0;
            redirect_pc = 6'($urandom);
            resume      = ($urandom % 8) == 0;
            step();
        end
        ir_ready = 1'b0; redirect = 1'b0; resume = 1'b0;
        if (halted) begin
            resume = 1'b1;
            step();
            resume = 1'b0;
        end

        // Asynchronous reset between edges while holding a valid word.
        wait_valid(10);
        #2 reset = 1'b1;
        #1;
        chk("areset_ir_valid", 32'(ir_valid), 32'd0);
        chk("areset_pc",       32'(pc),       32'd0);
        chk("areset_ir",       32'(ir),       32'd0);
        chk("areset_mem_en",   32'(mem_en),   32'd0);
        step();
        reset = 1'b0;
        step();
        chk("areset_restart_en",   32'(mem_en),   32'd1);
        chk("areset_restart_addr", 32'(mem_addr), 32'd0);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
